approx_divider_seq: RTL and testbench

APPROX_DIVIDER_SEQ -- requirements
Module: approx_divider_seq

---
 rtl/approx_divider_seq.sv | 185 ++++++++++++++++++
 tb/tb_approx_divider_seq.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/approx_divider_seq.sv
// approx_divider_seq: sequential approximate 64-bit unsigned divider.
//
// Each operand is truncated to its W most significant bits starting at its
// leading one. The truncated mantissas are divided by a restoring divider
// (one quotient bit per cycle, 2W cycles), and the quotient is then shifted
// back by the difference of the truncation amounts.
//
// Ports:
//   clk        - clock, all state changes on the rising edge
//   rst_n      - asynchronous active-low reset
//   in_valid   - operand pair a/b is present
//   in_ready   - high in IDLE only; accept = in_valid & in_ready
//   a, b       - 64-bit unsigned dividend / divisor
//   out_valid  - result q/dz is present (DONE state)
//   out_ready  - consumer takes the result; only honoured in DONE
//   q          - approximate quotient (all ones on divide-by-zero)
//   dz         - divide-by-zero flag for the current result
//
// Build option:
//   APPROX_DIV_ROUND_EN - when defined, the right shift applied to the
//   quotient rounds to nearest instead of truncating.
module approx_divider_seq #(
  parameter int W = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] q,
  output logic        dz
);

  typedef enum logic [2:0] {IDLE, DETECT, DIV, NORM, DONE} state_t;

  state_t state, state_nx;

  logic [63:0]    a_r, b_r;
  logic [5:0]     sa_r, sb_r;
  logic [W-1:0]   n_r;
  logic [W-1:0]   rem_r;
  logic [2*W-1:0] dvd_r;   // dividend bits shift out the top, quotient bits in at the bottom
  logic [5:0]     cnt_r;
  logic [63:0]    q_r;
  logic           dz_r;

  function automatic logic [5:0] lead_one(input logic [63:0] v);
    lead_one = 6'd0;
    for (int i = 0; i < 64; i++) begin
      if (v[i]) lead_one = 6'(i);
    end
  endfunction

  // Operand truncation
  logic [5:0]   k_a, l_b, sa, sb;
  logic [W-1:0] m, n;

  always_comb begin
    k_a = lead_one(a_r);
    l_b = lead_one(b_r);
    sa  = (k_a >= 6'(W-1)) ? k_a - 6'(W-1) : 6'd0;
    sb  = (l_b >= 6'(W-1)) ? l_b - 6'(W-1) : 6'd0;
    m   = W'(a_r >> sa);
    n   = W'(b_r >> sb);
  end

  // One restoring-division step. The remainder is always below n, so the
  // shifted-in value never needs more than W+1 bits.
  logic [W:0]   rem_sh;
  logic         ge;
  logic [W-1:0] rem_nx;

  always_comb begin
    rem_sh = {rem_r, dvd_r[2*W-1]};
    ge     = (rem_sh >= {1'b0, n_r});
    rem_nx = ge ? W'(rem_sh - {1'b0, n_r}) : W'(rem_sh);
  end

  // Renormalisation: q = qt * 2^s with s = sa - sb - W.
  logic signed [7:0] s;
  logic [7:0]        neg_s;
  logic [127:0]      wide;
  logic [63:0]       q_norm;

  always_comb begin
    s      = 8'(sa_r) - 8'(sb_r) - 8'(W);
    neg_s  = 8'(-s);
    wide   = 128'(dvd_r) << s[5:0];
    q_norm = 64'd0;
    if (s >= 0) begin
      q_norm = (|wide[127:64]) ? {64{1'b1}} : wide[63:0];
    end else if (neg_s > 8'(2*W)) begin
      q_norm = 64'd0;
    end else begin
`ifdef APPROX_DIV_ROUND_EN
      // Adding half an LSB before shifting equals adding bit (-s-1) after it.
      q_norm = (64'(dvd_r) + (64'd1 << (neg_s - 8'd1))) >> neg_s;
`else
      q_norm = 64'(dvd_r) >> neg_s;
`endif
    end
  end

  // NOTE: every state element, datapath included, is cleared by rst_n so a
  // reset mid-operation leaves nothing behind that could resurface later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r   <= '0;
      b_r   <= '0;
      sa_r  <= '0;
      sb_r  <= '0;
      n_r   <= '0;
      rem_r <= '0;
      dvd_r <= '0;
      cnt_r <= '0;
      q_r   <= '0;
      dz_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r <= a;
            b_r <= b;
          end
        end
        DETECT: begin
          sa_r  <= sa;
          sb_r  <= sb;
          n_r   <= n;
          dvd_r <= {m, {W{1'b0}}};
          rem_r <= '0;
          cnt_r <= '0;
          if (b_r == 64'd0) begin
            q_r  <= {64{1'b1}};
            dz_r <= 1'b1;
          end else begin
            dz_r <= 1'b0;
          end
        end
        DIV: begin
          rem_r <= rem_nx;
          dvd_r <= {dvd_r[2*W-2:0], ge};
          cnt_r <= cnt_r + 6'd1;
        end
        NORM:    q_r <= q_norm;
        default: ;
      endcase
    end
  end

  // NOTE: defaults are assigned first so no path through the case infers a latch.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = DETECT;
      end
      DETECT:  state_nx = (b_r == 64'd0) ? DONE : DIV;
      DIV:     if (cnt_r == 6'(2*W-1)) state_nx = NORM;
      NORM:    state_nx = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign q  = q_r;
  assign dz = dz_r;

endmodule

// File: tb/tb_approx_divider_seq.sv
// Testbench for approx_divider_seq (W=10): table of directed vectors with
// constant expectations, random vectors checked against a behavioural model,
// a held-result sequence and a mid-division reset sequence. Expected results
// go into a scoreboard queue at accept and are popped when out_valid rises.
// Latency is counted in clock edges starting with the accept edge itself.
module tb_approx_divider_seq;

  localparam int W = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] q;
  logic        dz;

  approx_divider_seq #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .dz        (dz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] q;
    logic        dz;
    int          hold;
  } vec_t;

  typedef struct {
    logic [63:0] q;
    logic        dz;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Behavioural reference: straight arithmetic on the truncated operands.
  function automatic exp_t model(input logic [63:0] ma, input logic [63:0] mb);
    exp_t        r;
    int          k, l, sa, sb, s, rs;
    logic [63:0] m, n, qt;
    logic [127:0] wide;
    r.dz = 1'b0;
    r.q  = 64'd0;
    if (mb == 64'd0) begin
      r.q  = {64{1'b1}};
      r.dz = 1'b1;
      return r;
    end
    k = 0;
    l = 0;
    for (int i = 0; i < 64; i++) begin
      if (ma[i]) k = i;
      if (mb[i]) l = i;
    end
    sa = (k - W + 1 > 0) ? k - W + 1 : 0;
    sb = (l - W + 1 > 0) ? l - W + 1 : 0;
    m  = ma >> sa;
    n  = mb >> sb;
    qt = (m << W) / n;
    s  = sa - sb - W;
    if (s >= 0) begin
      wide = {64'd0, qt} << s;
      r.q  = (wide[127:64] != 0) ? {64{1'b1}} : wide[63:0];
    end else begin
      rs = -s;
      if (rs > 2*W) r.q = 64'd0;
      else begin
        r.q = qt >> rs;
`ifdef APPROX_DIV_ROUND_EN
        r.q = r.q + ((qt >> (rs - 1)) & 64'd1);
`endif
      end
    end
    return r;
  endfunction

  task automatic run_txn(input logic [63:0] ta, input logic [63:0] tb,
                         input logic [63:0] eq, input logic edz, input int hold);
    int   edges;
    exp_t e;
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    a        = ta;
    b        = tb;
    in_valid = 1'b1;
    sb_q.push_back('{q: eq, dz: edz});
    @(posedge clk);                      // accept edge
    @(negedge clk);
    edges = 1;
    // in_valid stays high with junk operands: both must be ignored now.
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    while (!out_valid && edges < 200) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("latency", 64'(edges), edz ? 64'd2 : 64'(2*W+3));
    if (sb_q.size() == 0) begin
      check("scoreboard_nonempty", 64'd0, 64'd1);
    end else begin
      e = sb_q.pop_front();
      check("q", q, e.q);
      check("dz", 64'(dz), 64'(e.dz));
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        @(negedge clk);
        check("hold_q", q, e.q);
        check("hold_dz", 64'(dz), 64'(e.dz));
        check("hold_out_valid", 64'(out_valid), 64'd1);
        check("hold_in_ready", 64'(in_ready), 64'd0);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("in_ready_after", 64'(in_ready), 64'd1);
    check("out_valid_after", 64'(out_valid), 64'd0);
  endtask

  vec_t vecs[10];

  initial begin
    logic        saw_valid;
    logic [63:0] ra, rb;
    exp_t        e;

    vecs[0] = '{a: 64'd100, b: 64'd7, q: 64'd14, dz: 1'b0, hold: 0};
    vecs[1] = '{a: 64'h8000_0000_0000_0000, b: 64'd1, q: 64'h8000_0000_0000_0000, dz: 1'b0, hold: 0};
    vecs[2] = '{a: 64'd5, b: 64'd0, q: {64{1'b1}}, dz: 1'b1, hold: 0};
`ifdef APPROX_DIV_ROUND_EN
    vecs[3] = '{a: 64'd2, b: 64'd3, q: 64'd1, dz: 1'b0, hold: 0};
`else
    vecs[3] = '{a: 64'd2, b: 64'd3, q: 64'd0, dz: 1'b0, hold: 0};
`endif
    vecs[4] = '{a: 64'd0, b: 64'd9, q: 64'd0, dz: 1'b0, hold: 0};
    vecs[5] = '{a: 64'd1000, b: 64'd1000, q: 64'd1, dz: 1'b0, hold: 0};
    vecs[6] = '{a: {64{1'b1}}, b: 64'd1, q: 64'hFFC0_0000_0000_0000, dz: 1'b0, hold: 0};
    vecs[7] = '{a: 64'd1, b: {64{1'b1}}, q: 64'd0, dz: 1'b0, hold: 0};   // -s = 64 > 2W
    vecs[8] = '{a: 64'd100, b: 64'd7, q: 64'd14, dz: 1'b0, hold: 5};     // held in DONE
    vecs[9] = '{a: 64'd0, b: 64'd0, q: {64{1'b1}}, dz: 1'b1, hold: 2};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = 64'd0;
    b         = 64'd0;
    #12;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_q", q, 64'd0);
    check("rst_dz", 64'(dz), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++)
      run_txn(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].dz, vecs[i].hold);

    for (int i = 0; i < 16; i++) begin
      ra = {$urandom, $urandom} >> $urandom_range(0, 63);
      rb = {$urandom, $urandom} >> $urandom_range(0, 63);
      if (i % 8 == 7) rb = 64'd0;
      e = model(ra, rb);
      run_txn(ra, rb, e.q, e.dz, 0);
    end

    // Reset ten cycles into a division: operation abandoned, no result.
    @(negedge clk);
    a        = 64'd100;
    b        = 64'd7;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_q", q, 64'd0);
    check("midrst_dz", 64'(dz), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    check("no_valid_after_reset", 64'(saw_valid), 64'd0);
    run_txn(64'd100, 64'd7, 64'd14, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
